seq_pattern_ctrl: RTL and testbench

- Programmable serial-pattern detection controller, the configurable successor to the fixed 1011 Moore detector.
- Holds pattern, length and target-count configuration, and sequences detection runs through an IDLE/RUN/DONE FSM.
- Counts matches and signals completion.
- Sits between a config/control master and a single serial bit stream (x, x_valid).

---
 rtl/seq_pattern_ctrl.sv | 132 +++++++++++++
 tb/tb_seq_pattern_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_ctrl.sv
// Programmable serial-pattern detector: configurable pattern/length/target, IDLE/RUN/DONE sequencing.
// Define SEQ_PATTERN_NONOVERLAP_EN to clear the bit history on every match (non-overlapping detection).
module seq_pattern_ctrl #(
  parameter  int MAX_LEN = 8,
  parameter  int CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_wr,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               busy,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   RST_LEN     = LEN_W'(4);
  localparam logic [LEN_W-1:0]   FILL_MAX    = LEN_W'(MAX_LEN);

  state_t             state, state_next;
  logic [MAX_LEN-1:0] history, pattern;
  logic [LEN_W-1:0]   fill, len;
  logic [CNT_W-1:0]   target;

  logic [MAX_LEN-1:0] new_hist, mask;
  logic [LEN_W-1:0]   new_fill;
  logic [CNT_W-1:0]   cnt_inc;
  logic               hit, cfg_load, cfg_bad, run_start, shift, accept;

  // NOTE: every always_comb output gets a default first so no path leaves a value unassigned (no latches).
  always_comb begin
    state_next = state;
    cfg_load   = 1'b0;
    cfg_bad    = 1'b0;
    run_start  = 1'b0;
    shift      = 1'b0;
    accept     = 1'b0;

    new_hist = {history[MAX_LEN-2:0], x};
    new_fill = (fill == FILL_MAX) ? fill : fill + 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
    hit     = (((new_hist ^ pattern) & mask) == '0) && (new_fill >= len);
    cnt_inc = (&match_cnt) ? match_cnt : match_cnt + 1'b1;

    case (state)
      S_IDLE: begin
        // A config write always wins over a coincident start.
        if (cfg_wr) begin
          if (cfg_len == '0 || cfg_len > FILL_MAX) cfg_bad  = 1'b1;
          else                                     cfg_load = 1'b1;
        end else if (start) begin
          run_start  = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (x_valid) begin
          shift = 1'b1;
          if (hit) begin
            accept = 1'b1;
            if (target != '0 && cnt_inc == target) state_next = S_DONE;
          end
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      history   <= '0;
      fill      <= '0;
      pattern   <= RST_PATTERN;
      len       <= RST_LEN;
      target    <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
    end else begin
      state   <= state_next;
      match   <= accept;
      cfg_err <= cfg_bad;
      if (cfg_load) begin
        pattern <= cfg_pattern;
        len     <= cfg_len;
        target  <= cfg_target;
      end
      if (run_start) begin
        history   <= '0;
        fill      <= '0;
        match_cnt <= '0;
      end
      if (shift) begin
        history <= new_hist;
        fill    <= new_fill;
      end
      if (accept) begin
        match_cnt <= cnt_inc;
`ifdef SEQ_PATTERN_NONOVERLAP_EN
        history <= '0;
        fill    <= '0;
`endif
      end
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_pattern_ctrl.sv
// Directed self-checking bench for seq_pattern_ctrl; expected values are hand-computed per step.
module tb_seq_pattern_ctrl;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int LEN_W   = $clog2(MAX_LEN) + 1;

  logic               clk = 1'b0;
  logic               rst, cfg_wr, start, abort, x, x_valid;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               match, busy, done, cfg_err;
  logic [CNT_W-1:0]   match_cnt;

  int total = 0;
  int bad   = 0;

  seq_pattern_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target), .start(start), .abort(abort), .x(x), .x_valid(x_valid),
    .match(match), .match_cnt(match_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_bit(input logic b);
    x       = b;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic write_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                           input logic [CNT_W-1:0] t);
    cfg_pattern = p;
    cfg_len     = l;
    cfg_target  = t;
    cfg_wr      = 1'b1;
    tick();
    cfg_wr = 1'b0;
  endtask

  logic [6:0] seq2, exp2, seq3;
  logic [3:0] seq4;

  initial begin
    rst = 1'b1; cfg_wr = 1'b0; start = 1'b0; abort = 1'b0; x = 1'b0; x_valid = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    tick();
    tick();
    check("rst_match", match, 0);
    check("rst_cnt", match_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);
    rst = 1'b0;

    // 1: default pattern 1011
    do_start();
    check("t1_busy", busy, 1);
    check("t1_cnt0", match_cnt, 0);
    drive_bit(1'b1); check("t1_b1", match, 0);
    drive_bit(1'b0); check("t1_b2", match, 0);
    drive_bit(1'b1); check("t1_b3", match, 0);
    drive_bit(1'b1);
    check("t1_match", match, 1);
    check("t1_cnt", match_cnt, 1);
    check("t1_busy2", busy, 1);
    check("t1_done", done, 0);
    tick();
    check("t1_pulse_end", match, 0);
    check("t1_done2", done, 0);
    do_abort();
    check("t1_abort_busy", busy, 0);
    check("t1_abort_cnt", match_cnt, 1);

    // 2: overlap on 1011011
    do_start();
    check("t2_cnt_cleared", match_cnt, 0);
    seq2 = 7'b1011011;
`ifdef SEQ_PATTERN_NONOVERLAP_EN
    exp2 = 7'b0001000;
`else
    exp2 = 7'b0001001;
`endif
    for (int i = 0; i < 7; i++) begin
      drive_bit(seq2[6-i]);
      check($sformatf("t2_bit%0d", i + 1), match, exp2[6-i]);
    end
`ifdef SEQ_PATTERN_NONOVERLAP_EN
    check("t2_cnt", match_cnt, 1);
`else
    check("t2_cnt", match_cnt, 2);
`endif
    do_abort();

    // 3: pattern 110, len 3, target 2; coincident start must be ignored
    cfg_pattern = 8'b110; cfg_len = 4'd3; cfg_target = 8'd2;
    cfg_wr = 1'b1; start = 1'b1;
    tick();
    cfg_wr = 1'b0; start = 1'b0;
    check("t3_start_ignored", busy, 0);
    check("t3_cfg_ok", cfg_err, 0);
    do_start();
    check("t3_busy", busy, 1);
    seq3 = 7'b1101101;
    for (int i = 0; i < 6; i++) begin
      drive_bit(seq3[6-i]);
      check($sformatf("t3_match%0d", i + 1), match, (i == 2 || i == 5) ? 1 : 0);
      check($sformatf("t3_done%0d", i + 1), done, (i == 5) ? 1 : 0);
    end
    check("t3_busy_done", busy, 0);
    check("t3_cnt", match_cnt, 2);
    drive_bit(seq3[0]);
    check("t3_b7_match", match, 0);
    check("t3_b7_done", done, 0);
    check("t3_b7_cnt", match_cnt, 2);
    check("t3_b7_busy", busy, 0);
    write_cfg(8'b1011, 4'd4, 8'd0);

    // 4: invalid gaps with toggling x
    do_start();
    seq4 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      drive_bit(seq4[3-i]);
      check($sformatf("t4_valid%0d", i + 1), match, (i == 3) ? 1 : 0);
      x = ~seq4[3-i];
      tick();
      check($sformatf("t4_gap%0d", i + 1), match, 0);
    end
    check("t4_cnt", match_cnt, 1);
    do_abort();

    // 5: illegal lengths in IDLE, config write in RUN ignored
    write_cfg(8'b111, 4'd0, 8'd0);
    check("t5_len0_err", cfg_err, 1);
    tick();
    check("t5_err_pulse", cfg_err, 0);
    write_cfg(8'b111, 4'd9, 8'd0);
    check("t5_len9_err", cfg_err, 1);
    do_start();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    write_cfg(8'b111, 4'd3, 8'd0);
    check("t5_run_no_err", cfg_err, 0);
    check("t5_run_busy", busy, 1);
    drive_bit(1'b1);
    check("t5_default_kept", match, 1);
    do_abort();

    // 6: abort beats target-reaching match
    write_cfg(8'b1011, 4'd4, 8'd1);
    do_start();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    abort = 1'b1;
    drive_bit(1'b1);
    abort = 1'b0;
    check("t6_abort_busy", busy, 0);
    check("t6_abort_done", done, 0);
    check("t6_abort_match", match, 0);
    check("t6_abort_cnt", match_cnt, 0);
    tick();
    check("t6_abort_done2", done, 0);

    // 6b: rst mid-run wins over a target-reaching match
    do_start();
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rst = 1'b1;
    drive_bit(1'b1);
    rst = 1'b0;
    check("t6_rst_match", match, 0);
    check("t6_rst_cnt", match_cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_err", cfg_err, 0);
    do_start();
    for (int i = 0; i < 4; i++) drive_bit(seq4[3-i]);
    check("t6_cfg_reset_match", match, 1);
    check("t6_cfg_reset_done", done, 0);
    check("t6_cfg_reset_busy", busy, 1);
    do_abort();

    // len 1 boundary and counter saturation
    write_cfg(8'h01, 4'd1, 8'd0);
    do_start();
    drive_bit(1'b1);
    check("sat_first", match_cnt, 1);
    x = 1'b1;
    x_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    x_valid = 1'b0;
    check("sat_cnt", match_cnt, 255);
    check("sat_match", match, 1);
    check("sat_busy", busy, 1);
    do_abort();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
